// File: rtl/mux_sel_sequencer.sv
// rtl/mux_sel_sequencer.sv - 4:1 mux select scanner with settle delay and 4-bit frame capture; optional parity via MUX_SEQ_PARITY_EN
module mux_sel_sequencer #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cont,
    input  logic       y,
    output logic       c,
    output logic       d,
    output logic [3:0] frame,
    output logic       valid,
`ifdef MUX_SEQ_PARITY_EN
    output logic       parity,
`endif
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       ch;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       shadow;
    logic             settle_done;
    logic             last_ch;

    assign settle_done = (cnt == CNT_LAST);
    assign last_ch     = (ch == 2'd3);
    assign busy        = (state != IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: settle for SETTLE_CYCLES, sample once, loop or stop after ch3
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_done) begin
                    state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                if (!last_ch || cont) begin
                    state_nxt = SETTLE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: channel/select stepping, settle counter, sample shadow and frame output
    always_ff @(posedge clk) begin
        if (rst) begin
            ch     <= 2'd0;
            cnt    <= '0;
            shadow <= 3'd0;
            frame  <= 4'd0;
            valid  <= 1'b0;
            c      <= 1'b0;
            d      <= 1'b0;
`ifdef MUX_SEQ_PARITY_EN
            parity <= 1'b0;
`endif
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    // Select is parked at channel 0 so a new scan starts settled
                    ch    <= 2'd0;
                    cnt   <= '0;
                    {c,d} <= 2'b00;
                end
                SETTLE: begin
                    cnt <= cnt + CNT_W'(1);
                end
                SAMPLE: begin
                    cnt <= '0;
                    if (!last_ch) begin
                        shadow[ch] <= y;
                        ch         <= ch + 2'd1;
                        {c,d}      <= ch + 2'd1;
                    end else begin
                        // ch3 goes straight into the frame; it never needs a shadow slot
                        frame  <= {y, shadow};
                        valid  <= 1'b1;
                        ch     <= 2'd0;
                        {c,d}  <= 2'b00;
`ifdef MUX_SEQ_PARITY_EN
                        parity <= ^{y, shadow};
`endif
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// tb/tb_mux_sel_sequencer.sv - self-checking bench for mux_sel_sequencer with behavioural model and random stimulus
module tb_mux_sel_sequencer;

`ifdef MUX_SEQ_PARITY_EN
    localparam int SC   = 1;
    localparam int VOFF = 8;
    localparam int BP1  = 3;
    localparam int BP2  = 5;
`else
    localparam int SC   = 2;
    localparam int VOFF = 12;
    localparam int BP1  = 5;
    localparam int BP2  = 9;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       cont = 1'b0;
    logic       y;
    logic       c;
    logic       d;
    logic [3:0] frame;
    logic       valid;
    logic       busy;
    logic [3:0] iv = 4'b0000;
`ifdef MUX_SEQ_PARITY_EN
    logic       parity;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    // bench-side model of the gate-level mux
    assign y = iv[{c,d}];

    mux_sel_sequencer #(
        .SETTLE_CYCLES(SC),
        .CNT_W        (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .cont  (cont),
        .y     (y),
        .c     (c),
        .d     (d),
        .frame (frame),
        .valid (valid),
`ifdef MUX_SEQ_PARITY_EN
        .parity(parity),
`endif
        .busy  (busy)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // model: scan position counted in edges since start; channel n sampled every SC+1 edges
    int         m_pos = 0;
    bit         m_busy = 1'b0;
    logic [1:0] m_sel = 2'd0;
    logic [3:0] m_shadow = 4'd0;
    logic [3:0] m_frame = 4'd0;
    logic       m_valid = 1'b0;
    logic       m_par = 1'b0;
    int         m_n;

    always @(posedge clk) begin
        m_valid = 1'b0;
        if (rst) begin
            m_busy = 1'b0; m_pos = 0; m_sel = 2'd0;
            m_shadow = 4'd0; m_frame = 4'd0; m_par = 1'b0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy = 1'b1; m_pos = 0; m_sel = 2'd0;
            end
        end else begin
            m_pos++;
            if (m_pos % (SC + 1) == 0) begin
                m_n = m_pos / (SC + 1) - 1;
                m_shadow[m_n] = iv[m_sel];
                if (m_n < 3) begin
                    m_sel = 2'(m_n + 1);
                end else begin
                    m_frame = m_shadow;
                    m_par   = ^m_shadow;
                    m_valid = 1'b1;
                    m_sel   = 2'd0;
                    m_pos   = 0;
                    if (!cont) m_busy = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("sel",   8'({c,d}), 8'(m_sel));
            check("frame", 8'(frame), 8'(m_frame));
            check("valid", 8'(valid), 8'(m_valid));
            check("busy",  8'(busy),  8'(m_busy));
`ifdef MUX_SEQ_PARITY_EN
            check("parity", 8'(parity), 8'(m_par));
`endif
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // start a single frame (cont=0), optionally pulsing start again at offsets p1/p2
    task automatic run_frame(input logic [3:0] exp_frame, input int p1, input int p2);
        int vcount;
        int voff;
        vcount = 0;
        voff   = -1;
        cont  = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 1; j <= VOFF + 6; j++) begin
            start = (j == p1) || (j == p2);
            tick();
            if (valid) begin
                vcount++;
                voff = j;
            end
            if (j == VOFF) check("frame_lit", 8'(frame), 8'(exp_frame));
        end
        start = 1'b0;
        check("valid_count", 8'(vcount), 8'd1);
        check("valid_offset", 8'(voff), 8'(VOFF));
        check("idle_after", 8'(busy), 8'd0);
    endtask

    initial begin
        int vq[$];
        int after_drop;
        int guard;

        // reset with start and y high
        rst = 1'b1; start = 1'b1; iv = 4'b1111;
        tick();
        chk_en = 1'b1;
        check("rst_frame", 8'(frame), 8'd0);
        check("rst_busy",  8'(busy),  8'd0);
        tick();
        check("rst_valid", 8'(valid), 8'd0);
        check("rst_sel",   8'({c,d}), 8'd0);
        rst = 1'b0; start = 1'b0;
        tick();
        check("post_rst_busy",  8'(busy),  8'd0);
        check("post_rst_frame", 8'(frame), 8'd0);

        // single frame, i0..i3 = 1,0,1,1
        iv = 4'b1101;
        run_frame(4'b1101, -1, -1);

        // start pulses while busy are ignored
        iv = 4'b1101;
        run_frame(4'b1101, BP1, BP2);

        // continuous mode, i0..i3 = 0,1,1,0
        iv = 4'b0110; cont = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        after_drop = 0;
        for (int j = 1; j <= 4 * VOFF + 2; j++) begin
            if (j == 2 * VOFF + 2) iv[3] = 1'b1;
            if (j == 3 * VOFF + 2) cont = 1'b0;
            tick();
            if (valid) begin
                vq.push_back(j);
                if (j > 3 * VOFF + 2) after_drop++;
            end
            if (j == VOFF)     check("cont_frame1", 8'(frame), 8'b0110);
            if (j == 2 * VOFF) check("cont_frame2", 8'(frame), 8'b0110);
            if (j == 3 * VOFF) check("cont_frame3", 8'(frame), 8'b1110);
        end
        check("cont_valids", 8'(vq.size()), 8'd4);
        if (vq.size() == 4) begin
            check("cont_gap", 8'(vq[1] - vq[0]), 8'(VOFF));
            check("cont_last", 8'(vq[3]), 8'(4 * VOFF));
        end
        check("cont_after_drop", 8'(after_drop), 8'd1);
        guard = 0;
        while (busy && guard < 40) begin
            tick();
            guard++;
        end
        check("cont_idle", 8'(busy), 8'd0);

        // reset mid-frame discards the partial frame
        iv = 4'b1101; start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 1; j <= 6; j++) tick();
        rst = 1'b1;
        tick();
        check("midrst_sel",   8'({c,d}), 8'd0);
        check("midrst_busy",  8'(busy),  8'd0);
        check("midrst_frame", 8'(frame), 8'd0);
        check("midrst_valid", 8'(valid), 8'd0);
        rst = 1'b0;
        guard = 0;
        for (int j = 0; j < 20; j++) begin
            tick();
            if (valid) guard++;
        end
        check("midrst_novalid", 8'(guard), 8'd0);

`ifdef MUX_SEQ_PARITY_EN
        // i0..i3 = 1,1,1,0 -> frame 0111, even parity 1
        iv = 4'b0111;
        run_frame(4'b0111, -1, -1);
        check("parity_lit", 8'(parity), 8'd1);
`else
        iv = 4'b1101;
        run_frame(4'b1101, -1, -1);
`endif

        // randomized stimulus against the model
        for (int j = 0; j < 600; j++) begin
            rst   = ($urandom_range(0, 79) == 0);
            start = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) cont = ~cont;
            if ($urandom_range(0, 4) == 0) iv = 4'($urandom);
            tick();
        end
        rst = 1'b1; start = 1'b0; cont = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
